mbist_fault_sram: RTL and testbench

Parametrised single-port synchronous SRAM model used as the device under test for the MBIST/MBISR engines. It adds the following over a plain memory:
- per-bit write mask
- configurable read latency
- sequenced (multi-cycle) clear
- a small run-time programmable fault-injection table (stuck-at-0, stuck-at-1, read-flip)
- out-of-range access error flag

BIST controllers and the repair mux sit directly above it.

---
 rtl/mbist_mem_pkg.sv | 31 +++
 rtl/mbist_fault_inject.sv | 46 ++++
 rtl/mbist_fault_sram.sv | 176 +++++++++++++++++
 tb/tb_mbist_fault_sram.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_mem_pkg.sv
// Shared types for the fault-injecting SRAM model: fault encodings, FSM states
// and the fault-table entry layout.
`default_nettype none

package mbist_mem_pkg;

  // Entry fields are sized for the widest supported geometry and zero-extended.
  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_BIT_W  = 8;

  typedef enum logic [1:0] {
    FLT_OFF  = 2'b00,
    FLT_SA0  = 2'b01,
    FLT_SA1  = 2'b10,
    FLT_FLIP = 2'b11
  } flt_type_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_BIT_W-1:0]  bit_idx;
    flt_type_e               ftype;
  } flt_entry_t;

endpackage

`default_nettype wire

// File: rtl/mbist_fault_inject.sv
// Combinational read-path fault overlay: per bit, the highest-indexed matching
// entry decides whether the raw bit is forced low, forced high or inverted.
`default_nettype none

module mbist_fault_inject
  import mbist_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 256,
  parameter int NUM_FAULTS = 2
) (
  input  logic [DATA_WIDTH-1:0] raw_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  flt_entry_t            flt_tab_i [NUM_FAULTS],
  output logic [DATA_WIDTH-1:0] word_o
);

  flt_type_e sel;

  always_comb begin
    word_o = raw_i;
    sel    = FLT_OFF;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      sel = FLT_OFF;
      // Ascending scan so a later (higher) entry overrides an earlier one.
      for (int i = 0; i < NUM_FAULTS; i++) begin
        if (flt_tab_i[i].ftype != FLT_OFF &&
            flt_tab_i[i].addr == ENTRY_ADDR_W'(addr_i) &&
            flt_tab_i[i].addr < ENTRY_ADDR_W'(MEM_SIZE) &&
            flt_tab_i[i].bit_idx == ENTRY_BIT_W'(b)) begin
          sel = flt_tab_i[i].ftype;
        end
      end
      case (sel)
        FLT_SA0:  word_o[b] = 1'b0;
        FLT_SA1:  word_o[b] = 1'b1;
        FLT_FLIP: word_o[b] = ~raw_i[b];
        default:  word_o[b] = raw_i[b];
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mbist_fault_sram.sv
// Single-port SRAM model for MBIST: bit-masked writes, 1/2-cycle read latency,
// sequenced clear, programmable read-path faults and a sticky range error.
`default_nettype none

module mbist_fault_sram
  import mbist_mem_pkg::*;
#(
  parameter  int ADDR_WIDTH = 8,
  parameter  int DATA_WIDTH = 8,
  parameter  int MEM_SIZE   = 256,
  parameter  int RD_LATENCY = 1,
  parameter  int NUM_FAULTS = 2,
  localparam int FLT_IDX_W  = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
  localparam int FLT_BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  mem_en,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rvalid,
  output logic                  mem_err,
  input  logic                  flt_wr,
  input  logic [FLT_IDX_W-1:0]  flt_idx,
  input  logic [ADDR_WIDTH-1:0] flt_addr,
  input  logic [FLT_BIT_W-1:0]  flt_bit,
  input  logic [1:0]            flt_type
);

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  state_e                state_q;
  logic [IDX_W-1:0]      cnt_q;
  logic                  busy_q;
  logic                  err_q;
  flt_entry_t            flt_q [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  logic                  idle;
  logic                  in_range;
  logic                  acc;
  logic                  wr_en;
  logic                  rd_en;
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] raw_word;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] wr_word_d;

  assign idle      = (state_q == ST_IDLE);
  assign in_range  = (32'(mem_addr) < 32'(MEM_SIZE));
  assign acc       = idle & mem_en & ~rst;
  assign wr_en     = acc & mem_we & in_range;
  assign rd_en     = acc & ~mem_we;
  assign word_idx  = mem_addr[IDX_W-1:0];
  assign raw_word  = in_range ? mem_q[word_idx] : '0;
  assign wr_word_d = (mem_q[word_idx] & ~mem_wmask) | (mem_wdata & mem_wmask);

  mbist_fault_inject #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .NUM_FAULTS (NUM_FAULTS)
  ) u_inject (
    .raw_i     (raw_word),
    .addr_i    (mem_addr),
    .flt_tab_i (flt_q),
    .word_o    (rd_data_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init_start) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == IDX_W'(MEM_SIZE - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A range error in the same cycle as an accepted init_start is still reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (acc && !in_range) begin
      err_q <= 1'b1;
    end else if (idle && init_start) begin
      err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!idle) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[word_idx] <= wr_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FAULTS; i++) begin
        flt_q[i] <= '{addr: '0, bit_idx: '0, ftype: FLT_OFF};
      end
    end else if (flt_wr) begin
      for (int i = 0; i < NUM_FAULTS; i++) begin
        if (flt_idx == FLT_IDX_W'(i)) begin
          flt_q[i] <= '{addr:    ENTRY_ADDR_W'(flt_addr),
                        bit_idx: ENTRY_BIT_W'(flt_bit),
                        ftype:   flt_type_e'(flt_type)};
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] pipe_data_q;
      logic                  pipe_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_data_q  <= '0;
          pipe_valid_q <= 1'b0;
          rdata_q      <= '0;
          rvalid_q     <= 1'b0;
        end else begin
          pipe_valid_q <= rd_en;
          if (rd_en) pipe_data_q <= rd_data_d;
          rvalid_q <= pipe_valid_q;
          if (pipe_valid_q) rdata_q <= pipe_data_q;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_en;
          if (rd_en) rdata_q <= rd_data_d;
        end
      end
    end
  endgenerate

  assign init_busy  = busy_q;
  assign mem_rdata  = rdata_q;
  assign mem_rvalid = rvalid_q;
  assign mem_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mbist_fault_sram.sv
// Bench for mbist_fault_sram: directed table and sequences plus random traffic,
// driving a latency-1 and a latency-2 instance with identical stimulus.
`default_nettype none
`timescale 1ns/1ps

module tb_mbist_fault_sram;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MS = 16;
  localparam int NF = 2;

  logic          clk = 1'b0;
  logic          rst, init_start, mem_en, mem_we, flt_wr;
  logic [AW-1:0] mem_addr, flt_addr;
  logic [DW-1:0] mem_wdata, mem_wmask;
  logic [0:0]    flt_idx;
  logic [2:0]    flt_bit;
  logic [1:0]    flt_type;
  logic          busy1, busy2, rv1, rv2, err1, err2;
  logic [DW-1:0] rd1, rd2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mbist_fault_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .RD_LATENCY(1), .NUM_FAULTS(NF)) u_dut1 (
    .clk(clk), .rst(rst), .init_start(init_start), .init_busy(busy1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(rd1), .mem_rvalid(rv1), .mem_err(err1),
    .flt_wr(flt_wr), .flt_idx(flt_idx), .flt_addr(flt_addr), .flt_bit(flt_bit), .flt_type(flt_type)
  );

  mbist_fault_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .RD_LATENCY(2), .NUM_FAULTS(NF)) u_dut2 (
    .clk(clk), .rst(rst), .init_start(init_start), .init_busy(busy2),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(rd2), .mem_rvalid(rv2), .mem_err(err2),
    .flt_wr(flt_wr), .flt_idx(flt_idx), .flt_addr(flt_addr), .flt_bit(flt_bit), .flt_type(flt_type)
  );

  // Reference model: memory contents, remaining clear cycles, fault table, read queues.
  logic [DW-1:0] m_mem [MS];
  int            m_busy;
  logic          m_err;
  int            m_ftype [NF];
  int            m_faddr [NF];
  int            m_fbit  [NF];
  logic          m_v1, m_v2, m_pv;
  logic [DW-1:0] m_d1, m_d2, m_pd;

  function automatic logic [DW-1:0] apply_faults(int a, logic [DW-1:0] raw);
    logic [DW-1:0] w;
    w = raw;
    for (int b = 0; b < DW; b++) begin
      for (int i = NF - 1; i >= 0; i--) begin
        if (m_ftype[i] != 0 && m_faddr[i] == a && m_faddr[i] < MS && m_fbit[i] == b) begin
          if (m_ftype[i] == 1) w[b] = 1'b0;
          else if (m_ftype[i] == 2) w[b] = 1'b1;
          else w[b] = ~raw[b];
          break;
        end
      end
    end
    return w;
  endfunction

  task automatic model_edge();
    int            a;
    logic          rd;
    logic [DW-1:0] rdv;
    a = int'(mem_addr);
    if (rst) begin
      m_busy = MS;
      m_err  = 1'b0;
      for (int i = 0; i < NF; i++) m_ftype[i] = 0;
      for (int i = 0; i < MS; i++) m_mem[i] = '0;
      m_v1 = 0; m_d1 = '0; m_v2 = 0; m_d2 = '0; m_pv = 0; m_pd = '0;
    end else begin
      rd  = (m_busy == 0) && mem_en && !mem_we;
      rdv = (a < MS) ? apply_faults(a, m_mem[a]) : '0;
      m_v2 = m_pv;
      if (m_pv) m_d2 = m_pd;
      m_pv = rd;
      m_pd = rdv;
      m_v1 = rd;
      if (rd) m_d1 = rdv;
      if (m_busy == 0) begin
        if (init_start) m_err = 1'b0;
        if (mem_en && a >= MS) m_err = 1'b1;
        if (mem_en && mem_we && a < MS) m_mem[a] = (m_mem[a] & ~mem_wmask) | (mem_wdata & mem_wmask);
        if (init_start) begin
          for (int i = 0; i < MS; i++) m_mem[i] = '0;
          m_busy = MS;
        end
      end else begin
        m_busy = m_busy - 1;
      end
      if (flt_wr) begin
        m_ftype[flt_idx] = int'(flt_type);
        m_faddr[flt_idx] = int'(flt_addr);
        m_fbit[flt_idx]  = int'(flt_bit);
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_busy1", busy1, m_busy > 0);
    chk("model_busy2", busy2, m_busy > 0);
    chk("model_err1", err1, m_err);
    chk("model_err2", err2, m_err);
    chk("model_rv1", rv1, m_v1);
    chk("model_rd1", rd1, m_d1);
    chk("model_rv2", rv2, m_v2);
    chk("model_rd2", rd2, m_d2);
  endtask

  task automatic wr(int a, logic [DW-1:0] d, logic [DW-1:0] m);
    mem_en = 1; mem_we = 1; mem_addr = AW'(a); mem_wdata = d; mem_wmask = m;
    step();
    mem_en = 0; mem_we = 0;
  endtask

  task automatic rd_chk(int a, logic [DW-1:0] exp, string name);
    mem_en = 1; mem_we = 0; mem_addr = AW'(a);
    step();
    mem_en = 0;
    chk({name, "_rv1"}, rv1, 1);
    chk({name, "_rd1"}, rd1, exp);
    chk({name, "_rv2_early"}, rv2, 0);
    step();
    chk({name, "_rv2"}, rv2, 1);
    chk({name, "_rd2"}, rd2, exp);
    chk({name, "_rv1_pulse"}, rv1, 0);
  endtask

  task automatic setf(int i, int a, int b, int t);
    flt_wr = 1; flt_idx = 1'(i); flt_addr = AW'(a); flt_bit = 3'(b); flt_type = 2'(t);
    step();
    flt_wr = 0;
  endtask

  // Counts busy cycles starting from the cycle already observed after the triggering edge.
  task automatic count_busy(output int n);
    n = busy1 ? 1 : 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (busy1) n++;
      else break;
    end
  endtask

  typedef struct {
    logic          we;
    int            addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0]  = '{1'b1, 2,  8'hFF, 8'hFF, 8'h00};
    vecs[1]  = '{1'b1, 2,  8'h00, 8'h0F, 8'h00};
    vecs[2]  = '{1'b0, 2,  8'h00, 8'h00, 8'hF0};
    vecs[3]  = '{1'b1, 4,  8'h3C, 8'hFF, 8'h00};
    vecs[4]  = '{1'b1, 20, 8'h99, 8'hFF, 8'h00};
    vecs[5]  = '{1'b0, 4,  8'h00, 8'h00, 8'h3C};
    vecs[6]  = '{1'b1, 7,  8'h12, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 7,  8'h00, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 9,  8'hAB, 8'hF0, 8'h00};
    vecs[9]  = '{1'b1, 9,  8'hCD, 8'h0F, 8'h00};
    vecs[10] = '{1'b0, 9,  8'h00, 8'h00, 8'hAD};
    vecs[11] = '{1'b0, 20, 8'h00, 8'h00, 8'h00};

    rst = 1; init_start = 0; mem_en = 0; mem_we = 0; mem_addr = '0;
    mem_wdata = '0; mem_wmask = '0; flt_wr = 0; flt_idx = '0; flt_addr = '0; flt_bit = '0; flt_type = '0;

    // Reset clear, with a write to addr 3 attempted during the busy window.
    step();
    chk("rst_busy", busy1, 1);
    chk("rst_rv", rv1, 0);
    chk("rst_rdata", rd1, 0);
    chk("rst_err", err1, 0);
    rst = 0;
    mem_en = 1; mem_we = 1; mem_addr = 5'd3; mem_wdata = 8'h5A; mem_wmask = 8'hFF;
    n = busy1 ? 1 : 0;
    for (int k = 0; k < 100; k++) begin
      if (k == 3) begin mem_en = 0; mem_we = 0; end
      step();
      if (busy1) n++;
      else break;
    end
    chk("rst_busy_len", n, MS);

    for (int a = 0; a < MS; a++) rd_chk(a, 8'h00, "clear_rd");

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].we) wr(vecs[v].addr, vecs[v].wdata, vecs[v].wmask);
      else rd_chk(vecs[v].addr, vecs[v].exp, "vec_rd");
    end
    chk("oob_err_set", err1, 1);

    wr(5, 8'hA5, 8'hFF);
    setf(0, 5, 1, 2);
    rd_chk(5, 8'hA7, "flt_sa1");
    setf(1, 5, 7, 3);
    rd_chk(5, 8'h27, "flt_flip");
    // Rewriting entry 0 drops its bit-1 force; bit 7 goes to the higher entry's flip.
    setf(0, 5, 7, 1);
    rd_chk(5, 8'h25, "flt_prio");
    setf(0, 5, 7, 0);
    setf(1, 5, 7, 0);
    rd_chk(5, 8'hA5, "flt_off");

    init_start = 1;
    step();
    init_start = 0;
    chk("init_err_clr", err1, 0);
    chk("init_busy", busy1, 1);
    count_busy(n);
    chk("init_busy_len", n, MS);

    wr(0, 8'h11, 8'hFF);
    wr(1, 8'h22, 8'hFF);
    wr(2, 8'h33, 8'hFF);
    mem_en = 1; mem_we = 0;
    mem_addr = 5'd0; step(); chk("pipe_v0", rv2, 0);
    mem_addr = 5'd1; step(); chk("pipe_v1", rv2, 1); chk("pipe_d1", rd2, 8'h11);
    mem_addr = 5'd2; step(); chk("pipe_v2", rv2, 1); chk("pipe_d2", rd2, 8'h22);
    mem_en = 0;      step(); chk("pipe_v3", rv2, 1); chk("pipe_d3", rd2, 8'h33);
    step(); chk("pipe_end", rv2, 0); chk("pipe_hold", rd2, 8'h33);

    init_start = 1;
    step();
    init_start = 0;
    for (int k = 0; k < 7; k++) step();
    chk("midclr_busy", busy1, 1);
    rst = 1;
    step();
    rst = 0;
    count_busy(n);
    chk("midclr_busy_len", n, MS);
    rd_chk(1, 8'h00, "midclr_rd");

    for (int c = 0; c < 800; c++) begin
      int sel;
      sel        = int'($urandom_range(0, 9));
      mem_addr   = (sel == 9) ? AW'(16 + $urandom_range(0, 15)) : AW'(sel);
      mem_en     = ($urandom_range(0, 3) != 0);
      mem_we     = 1'($urandom_range(0, 1));
      mem_wdata  = 8'($urandom);
      mem_wmask  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      flt_wr     = ($urandom_range(0, 7) == 0);
      flt_idx    = 1'($urandom);
      flt_addr   = AW'($urandom_range(0, 9) == 9 ? 16 + $urandom_range(0, 15) : $urandom_range(0, 8));
      flt_bit    = 3'($urandom);
      flt_type   = 2'($urandom);
      init_start = ($urandom_range(0, 99) == 0);
      rst        = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 0; init_start = 0; mem_en = 0; flt_wr = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
